// File: rtl/uart_rx_if.sv
// CPU-side receive handshake: FIFO-head presentation (irr/r_data) and pop request (ack).
interface uart_rx_if;
  logic       irr;
  logic [7:0] r_data;
  logic       ack;

  modport master (output irr, output r_data, input ack);
  modport slave  (input irr, input r_data, output ack);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding a small byte FIFO whose head is presented to the CPU.
module uart_rx #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  uart_rx_if.master   cpu,
  output logic        overrun,
  output logic        frame_err
);

  localparam int TW = $clog2(CLK_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TMR_FULL = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] TMR_HALF = TW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          push, ferr;
  logic          rx_p0, rx_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   rd_ptr, wr_ptr;
  logic          ack_q;
  logic          empty, full, pop, wr_en, drop;

  // Stage p0 -> s: two-flop synchroniser, idle-high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tmr   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    push      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          tmr_nxt   = TMR_HALF;
        end
      end
      START: begin
        if (tmr == '0) begin
          // A line back high at mid-start-bit was a glitch, not a frame
          if (!rx_s) begin
            state_nxt = DATA;
            idx_nxt   = '0;
            tmr_nxt   = TMR_FULL;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      DATA: begin
        if (tmr == '0) begin
          shreg_nxt[idx] = rx_s;
          tmr_nxt        = TMR_FULL;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      STOP: begin
        if (tmr == '0) begin
          // Leaving mid-stop-bit is safe: the line is still high
          state_nxt = IDLE;
          if (rx_s) push = 1'b1;
          else      ferr = 1'b1;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  // Pop is resolved first, so a full FIFO popping this cycle still accepts the push
  assign pop   = cpu.ack & ~ack_q & ~empty;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      ack_q     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ack_q     <= cpu.ack;
      overrun   <= drop;
      frame_err <= ferr;
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign cpu.irr    = !empty;
  assign cpu.r_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, hand-built corner sequences, and a random run against a queue model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic overrun, frame_err;

  uart_rx_if bus();

  uart_rx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx(rx), .cpu(bus), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ovr_cnt = 0, fe_cnt = 0, ovr_wide = 0, fe_wide = 0;
  logic ovr_prev = 1'b0, fe_prev = 1'b0;
  logic irr_trace [0:80];

  always @(negedge clk) begin
    if (overrun) begin
      ovr_cnt++;
      if (ovr_prev) ovr_wide++;
    end
    if (frame_err) begin
      fe_cnt++;
      if (fe_prev) fe_wide++;
    end
    ovr_prev = overrun;
    fe_prev  = frame_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; optional ack rising edge and reset pulse at given cycle offsets (-1 = none)
  task automatic send(input logic [7:0] d, input bit stop, input int ack_c, input int rst_c);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int c = 0; c < 80; c++) begin
      if (c % 8 == 0) rx = bits[c/8];
      if (c == ack_c) bus.ack = 1'b1;
      if (c == ack_c + 2) bus.ack = 1'b0;
      if (c == rst_c) reset = 1'b1;
      if (c == rst_c + 1) reset = 1'b0;
      tick();
      irr_trace[c+1] = bus.irr;
    end
    bus.ack = 1'b0;
    rx = 1'b1;
    tick();
  endtask

  task automatic pop();
    bus.ack = 1'b1;
    repeat (4) tick();
    bus.ack = 1'b0;
    tick();
  endtask

  typedef struct {
    bit         send;
    logic [7:0] data;
    bit         stop;
    int         pops;
    bit         exp_irr;
    logic [7:0] exp_head;
    int         exp_ovr;
    int         exp_fe;
  } vec_t;

  vec_t vecs [18];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int o0, f0;
    logic [7:0] q [$];
    logic [7:0] exp_seq [4];

    vecs[0]  = '{1, 8'h01, 1, 0, 1, 8'h01, 0, 0};
    vecs[1]  = '{1, 8'h02, 1, 0, 1, 8'h01, 0, 0};
    vecs[2]  = '{1, 8'h03, 1, 0, 1, 8'h01, 0, 0};
    vecs[3]  = '{1, 8'h04, 1, 0, 1, 8'h01, 0, 0};
    vecs[4]  = '{0, 8'h00, 1, 2, 1, 8'h03, 0, 0};
    vecs[5]  = '{1, 8'h05, 1, 0, 1, 8'h03, 0, 0};
    vecs[6]  = '{1, 8'h06, 1, 0, 1, 8'h03, 0, 0};
    vecs[7]  = '{1, 8'h77, 1, 0, 1, 8'h03, 1, 0};
    vecs[8]  = '{0, 8'h00, 1, 1, 1, 8'h04, 0, 0};
    vecs[9]  = '{0, 8'h00, 1, 1, 1, 8'h05, 0, 0};
    vecs[10] = '{0, 8'h00, 1, 1, 1, 8'h06, 0, 0};
    vecs[11] = '{0, 8'h00, 1, 1, 0, 8'h00, 0, 0};
    vecs[12] = '{1, 8'h3C, 0, 0, 0, 8'h00, 0, 1};
    vecs[13] = '{1, 8'h42, 1, 0, 1, 8'h42, 0, 0};
    vecs[14] = '{0, 8'h00, 1, 1, 0, 8'h00, 0, 0};
    vecs[15] = '{0, 8'h00, 1, 1, 0, 8'h00, 0, 0};
    vecs[16] = '{1, 8'h5A, 1, 0, 1, 8'h5A, 0, 0};
    vecs[17] = '{0, 8'h00, 1, 1, 0, 8'h00, 0, 0};

    bus.ack = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_irr", bus.irr, 0);
    check("reset_rdata", bus.r_data, 8'h00);
    check("reset_overrun", overrun, 0);
    check("reset_frame_err", frame_err, 0);

    // Single byte: push lands on edge 79 of the frame, irr visible right after
    send(8'hA5, 1, -1, -1);
    check("lat_irr_before", irr_trace[78], 0);
    check("lat_irr_after", irr_trace[79], 1);
    check("single_rdata", bus.r_data, 8'hA5);
    pop();
    check("single_pop_irr", bus.irr, 0);
    check("single_pop_rdata", bus.r_data, 8'h00);

    for (int i = 0; i < 18; i++) begin
      o0 = ovr_cnt;
      f0 = fe_cnt;
      if (vecs[i].send) send(vecs[i].data, vecs[i].stop, -1, -1);
      for (int p = 0; p < vecs[i].pops; p++) pop();
      check($sformatf("vec%0d_irr", i), bus.irr, vecs[i].exp_irr);
      check($sformatf("vec%0d_head", i), bus.r_data, vecs[i].exp_head);
      check($sformatf("vec%0d_ovr", i), ovr_cnt - o0, vecs[i].exp_ovr);
      check($sformatf("vec%0d_fe", i), fe_cnt - f0, vecs[i].exp_fe);
    end

    // Full FIFO with ack rising edge on the push cycle: pop then push, no overrun
    send(8'h11, 1, -1, -1);
    send(8'h22, 1, -1, -1);
    send(8'h33, 1, -1, -1);
    send(8'h44, 1, -1, -1);
    o0 = ovr_cnt;
    send(8'h77, 1, 78, -1);
    check("ovr_ack_no_overrun", ovr_cnt - o0, 0);
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h77};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_ack_head%0d", i), bus.r_data, exp_seq[i]);
      pop();
    end
    check("ovr_ack_empty", bus.irr, 0);

    // Two-cycle glitch on rx
    o0 = ovr_cnt;
    f0 = fe_cnt;
    rx = 1'b0;
    tick();
    tick();
    rx = 1'b1;
    repeat (30) tick();
    check("glitch_irr", bus.irr, 0);
    check("glitch_fe", fe_cnt - f0, 0);
    check("glitch_ovr", ovr_cnt - o0, 0);
    send(8'h5A, 1, -1, -1);
    check("glitch_next_head", bus.r_data, 8'h5A);
    pop();
    check("glitch_next_empty", bus.irr, 0);

    // Reset during bit 4 of 0xFF with one byte already queued
    send(8'h99, 1, -1, -1);
    check("rst_pre_head", bus.r_data, 8'h99);
    o0 = ovr_cnt;
    f0 = fe_cnt;
    send(8'hFF, 1, -1, 36);
    check("rst_irr_before", irr_trace[36], 1);
    check("rst_irr_after", irr_trace[37], 0);
    check("rst_end_irr", bus.irr, 0);
    check("rst_end_rdata", bus.r_data, 8'h00);
    check("rst_end_overrun", overrun, 0);
    check("rst_end_frame_err", frame_err, 0);
    check("rst_no_fe", fe_cnt - f0, 0);
    check("rst_no_ovr", ovr_cnt - o0, 0);
    send(8'h81, 1, -1, -1);
    check("rst_next_irr", bus.irr, 1);
    check("rst_next_head", bus.r_data, 8'h81);
    pop();
    check("rst_next_empty", bus.irr, 0);

    // Random traffic against a queue model
    q = {};
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      bit stop;
      int npop, eo, ef;
      d = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      npop = $urandom_range(0, 2);
      eo = (stop && q.size() == DEPTH) ? 1 : 0;
      ef = stop ? 0 : 1;
      if (stop && q.size() < DEPTH) q.push_back(d);
      o0 = ovr_cnt;
      f0 = fe_cnt;
      send(d, stop, -1, -1);
      for (int p = 0; p < npop; p++) begin
        pop();
        if (q.size() > 0) void'(q.pop_front());
      end
      check($sformatf("rnd%0d_irr", i), bus.irr, (q.size() != 0));
      check($sformatf("rnd%0d_head", i), bus.r_data, (q.size() != 0) ? q[0] : 8'h00);
      check($sformatf("rnd%0d_ovr", i), ovr_cnt - o0, eo);
      check($sformatf("rnd%0d_fe", i), fe_cnt - f0, ef);
    end

    check("overrun_single_cycle", ovr_wide, 0);
    check("frame_err_single_cycle", fe_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
